perm_shuffle_seq: RTL and testbench

//   Sequencer for the 16-entry nibble permutation datapath. On a start request it:
//   - initialises the datapath to identity;
//   - applies ROUNDS permutation steps, each choosing one of 8 maps from an internal LFSR;
//   - streams the resulting 16 four-bit values out over a valid/ready port.

---
 rtl/perm_shuffle_seq.sv | 102 ++++++++++
 tb/tb_perm_shuffle_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_shuffle_seq.sv
`default_nettype none
// ============================================================================
// Module : perm_shuffle_seq
// Shuffle sequencer: identity init, ROUNDS LFSR-chosen permutation steps,
// then streams the 16 resulting nibbles over a valid/ready port.
// Rev    : 1.0  initial release
// ============================================================================
module perm_shuffle_seq #(
  parameter int unsigned ROUNDS    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  output logic        perm_init,
  output logic        perm_step,
  output logic [2:0]  perm_sel,
  input  logic [63:0] seq_all,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_last,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    SHUFFLE = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

  state_t      state;
  logic [15:0] lfsr;
  logic [3:0]  idx;
  logic [7:0]  round_cnt;
  logic        done_q;

  logic [15:0] lfsr_next;
  logic [15:0] seed_eff;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // A zero seed would lock the LFSR, so it is replaced by the default seed
  assign seed_eff  = (seed_in == 16'd0) ? LFSR_SEED : seed_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      idx       <= 4'd0;
      round_cnt <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= seed_eff;
          if (start) state <= INIT;
        end
        INIT: begin
          round_cnt <= 8'd0;
          state     <= SHUFFLE;
        end
        SHUFFLE: begin
          lfsr      <= lfsr_next;
          round_cnt <= round_cnt + 8'd1;
          if (round_cnt == LAST_ROUND) begin
            idx   <= 4'd0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign perm_init = (state == INIT);
  assign perm_step = (state == SHUFFLE);
  assign perm_sel  = perm_step ? lfsr[2:0] : 3'd0;
  assign out_valid = (state == EMIT);
  assign out_data  = out_valid ? seq_all[{idx, 2'b00} +: 4] : 4'd0;
  assign out_last  = out_valid && (idx == 4'd15);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_perm_shuffle_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_perm_shuffle_seq
// Scoreboard bench for perm_shuffle_seq with a stub datapath value.
// Rev    : 1.0  initial release
// ============================================================================
module tb_perm_shuffle_seq;

  localparam int          ROUNDS = 8;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'd0;
  logic        perm_init, perm_step;
  logic [2:0]  perm_sel;
  logic [63:0] seq_all = 64'h0123456789ABCDEF;
  logic        busy, out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        out_last, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model_lfsr = SEED;
  logic [2:0]  sel_q[$];
  logic [4:0]  data_q[$];
  logic [2:0]  obs_sel[ROUNDS];

  perm_shuffle_seq #(.ROUNDS(ROUNDS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .perm_init(perm_init), .perm_step(perm_step), .perm_sel(perm_sel),
    .seq_all(seq_all), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected step selects and stream beats for one shuffle from the model
  task automatic push_expected();
    for (int r = 0; r < ROUNDS; r++) begin
      sel_q.push_back(model_lfsr[2:0]);
      model_lfsr = lfsr_adv(model_lfsr);
    end
    for (int i = 0; i < 16; i++)
      data_q.push_back({(i == 15), seq_all[4*i +: 4]});
  endtask

  task automatic do_shuffle(input bit rand_ready, input bit poke_busy,
                            input bit load, input logic [15:0] seed);
    logic [2:0] exp_s;
    logic [4:0] exp_d;
    int beats;
    int cycles;
    @(negedge clk);
    start = 1'b1;
    if (load) begin
      seed_load  = 1'b1;
      seed_in    = seed;
      model_lfsr = (seed == 16'd0) ? SEED : seed;
    end
    push_expected();
    @(negedge clk);
    start = 1'b0;
    seed_load = 1'b0;
    n_tests++;
    if (perm_init !== 1'b1 || perm_step !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL init_cycle: init=%b step=%b busy=%b required 1 0 1", perm_init, perm_step, busy);
    end
    for (int r = 0; r < ROUNDS; r++) begin
      @(negedge clk);
      if (poke_busy && r == 2) begin
        start = 1'b1; seed_load = 1'b1; seed_in = 16'h5555;
      end else begin
        start = 1'b0; seed_load = 1'b0;
      end
      exp_s = sel_q.pop_front();
      obs_sel[r] = perm_sel;
      n_tests++;
      if (perm_step !== 1'b1 || perm_init !== 1'b0 || perm_sel !== exp_s) begin
        n_fail++;
        $display("FAIL step_%0d: step=%b init=%b sel=%0d required 1 0 %0d", r, perm_step, perm_init, perm_sel, exp_s);
      end
    end
    @(negedge clk);
    start = 1'b0;
    seed_load = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || perm_step !== 1'b0) begin
      n_fail++;
      $display("FAIL first_valid: out_valid=%b step=%b required 1 0", out_valid, perm_step);
    end
    beats = 0;
    cycles = 0;
    while (beats < 16 && cycles < 400) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      exp_d = data_q[0];
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_d[3:0] || out_last !== exp_d[4]) begin
        n_fail++;
        $display("FAIL beat_%0d: valid=%b data=%h last=%b required 1 %h %b", beats, out_valid, out_data, out_last, exp_d[3:0], exp_d[4]);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        void'(data_q.pop_front());
        beats++;
      end
    end
    if (beats < 16) begin
      n_tests++;
      n_fail++;
      $display("FAIL stream_timeout: beats=%0d required 16", beats);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1 0 0", done, out_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({perm_init, perm_step, perm_sel, busy, out_valid, out_data, out_last, done} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%b required 0", {perm_init, perm_step, perm_sel, busy, out_valid, out_data, out_last, done});
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (ROUNDS + 1) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_emit: out_valid=%b required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({perm_init, perm_step, perm_sel, busy, out_valid, out_data, out_last, done} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%b required 0", {perm_init, perm_step, perm_sel, busy, out_valid, out_data, out_last, done});
    end
    @(negedge clk);
    rst = 1'b0;
    model_lfsr = SEED;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_seed_one();
    logic [2:0] c_sel[ROUNDS] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    @(negedge clk);
    seed_load = 1'b1;
    seed_in = 16'h0001;
    model_lfsr = 16'h0001;
    @(negedge clk);
    seed_load = 1'b0;
    do_shuffle(1'b0, 1'b0, 1'b0, 16'd0);
    for (int r = 0; r < ROUNDS; r++) begin
      n_tests++;
      if (obs_sel[r] !== c_sel[r]) begin
        n_fail++;
        $display("FAIL seed1_sel_%0d: sel=%0d required %0d", r, obs_sel[r], c_sel[r]);
      end
    end
  endtask

  task automatic test_random_ready();
    do_shuffle(1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_ignore_busy();
    do_shuffle(1'b0, 1'b1, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_poke_queued: busy=%b required 0", busy);
    end
  endtask

  task automatic test_zero_seed();
    @(negedge clk);
    seed_load = 1'b1;
    seed_in = 16'd0;
    model_lfsr = SEED;
    @(negedge clk);
    seed_load = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_load_busy: busy=%b required 0", busy);
    end
    do_shuffle(1'b0, 1'b0, 1'b0, 16'd0);
    n_tests++;
    if (obs_sel[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL zero_seed_sel: sel=%0d required 1", obs_sel[0]);
    end
  endtask

  task automatic test_seed_and_start();
    seq_all = 64'hFEDCBA9876543210;
    do_shuffle(1'b0, 1'b0, 1'b1, 16'h0006);
    n_tests++;
    if (obs_sel[0] !== 3'd6) begin
      n_fail++;
      $display("FAIL seed_start_sel: sel=%0d required 6", obs_sel[0]);
    end
  endtask

  task automatic test_reset_mid_shuffle();
    seq_all = 64'h0123456789ABCDEF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (perm_step !== 1'b1) begin
      n_fail++;
      $display("FAIL round3_step: step=%b required 1", perm_step);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || perm_step !== 1'b0 || perm_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b step=%b sel=%0d required 0 0 0", busy, perm_step, perm_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    model_lfsr = SEED;
    do_shuffle(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_back_to_back();
    seq_all = {$urandom, $urandom};
    do_shuffle(1'b1, 1'b0, 1'b0, 16'd0);
    seq_all = {$urandom, $urandom};
    do_shuffle(1'b1, 1'b0, 1'b1, 16'hBEEF);
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_random_ready();
    test_ignore_busy();
    test_zero_seed();
    test_seed_and_start();
    test_reset_mid_shuffle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
